// File: rtl/ex_pkg.sv
// ex_pkg: ALU codes, M-extension op encodings, MD FSM states and forwarding selects.
package ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_WB,
    FWD_MEM
  } fwd_sel_t;

  // MEM has priority over WB; x0 is never forwarded.
  function automatic fwd_sel_t fwd_select(input logic       rw_mem,
                                          input logic [4:0] rd_mem,
                                          input logic       rw_wb,
                                          input logic [4:0] rd_wb,
                                          input logic [4:0] rs);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (rw_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
      sel = FWD_MEM;
    end else if (rw_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_stage_md_if.sv
// ex_stage_md_if: M-op handshake and MEM/WB forwarding bus seen by the EX stage.
interface ex_stage_md_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned MDOP_W = 3
);
  logic              MDValid_ex;
  logic [MDOP_W-1:0] MDOp_ex;
  logic              flush_ex;
  logic              Stall_ex;
  logic [4:0]        rdAddr_mem;
  logic [4:0]        rdAddr_wb;
  logic [XLEN-1:0]   ALUResult_mem;
  logic [XLEN-1:0]   RegWriteData_wb;
  logic              RegWrite_mem;
  logic              RegWrite_wb;

  modport master (
    output MDValid_ex, MDOp_ex, flush_ex,
    output rdAddr_mem, rdAddr_wb, ALUResult_mem, RegWriteData_wb, RegWrite_mem, RegWrite_wb,
    input  Stall_ex
  );

  modport slave (
    input  MDValid_ex, MDOp_ex, flush_ex,
    input  rdAddr_mem, rdAddr_wb, ALUResult_mem, RegWriteData_wb, RegWrite_mem, RegWrite_wb,
    output Stall_ex
  );
endinterface

// File: rtl/alu.sv
// alu: combinational RV32/RV64 integer ALU.
module alu
  import ex_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ALUCODE_W = 4
) (
  input  logic [ALUCODE_W-1:0] ALUCode,
  input  logic [XLEN-1:0]      A,
  input  logic [XLEN-1:0]      B,
  output logic [XLEN-1:0]      Result
);

  localparam int unsigned SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  assign shamt = B[SH_W-1:0];

  always_comb begin
    Result = '0;
    case (ALUCode)
      ALUCODE_W'(ALU_ADD):  Result = A + B;
      ALUCODE_W'(ALU_SUB):  Result = A - B;
      ALUCODE_W'(ALU_SLL):  Result = A << shamt;
      ALUCODE_W'(ALU_SLT):  Result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      ALUCODE_W'(ALU_SLTU): Result = {{(XLEN-1){1'b0}}, (A < B)};
      ALUCODE_W'(ALU_XOR):  Result = A ^ B;
      ALUCODE_W'(ALU_SRL):  Result = A >> shamt;
      ALUCODE_W'(ALU_SRA):  Result = $signed(A) >>> shamt;
      ALUCODE_W'(ALU_OR):   Result = A | B;
      ALUCODE_W'(ALU_AND):  Result = A & B;
      ALUCODE_W'(ALU_LUI):  Result = B;
      default:              Result = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative RV-M multiply/divide with IDLE/BUSY/DONE FSM and stall.
// MD_FAST_MUL_EN: multiplies complete from IDLE with a single-cycle product.
module md_unit
  import ex_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned MDOP_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              md_valid,
  input  logic [MDOP_W-1:0] md_op,
  input  logic              flush,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              md_stall,
  output logic              md_done,
  output logic [XLEN-1:0]   md_result
);

  localparam int unsigned   CNT_W   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic op_is(input logic [MDOP_W-1:0] op, input logic [2:0] code);
    return op == MDOP_W'(code);
  endfunction

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   md_result_q, md_result_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [MDOP_W-1:0] op_q, op_d;
  logic              neg_q, neg_d;

  logic            in_div, in_rem, in_sdiv, a_signed, b_signed, sign_a, sign_b;
  logic            div_by_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            q_div, q_rem, q_mul_lo;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] quo_rem;
  logic [2*XLEN-1:0] prod;

  assign in_div   = op_is(md_op, MD_DIV) | op_is(md_op, MD_DIVU) |
                    op_is(md_op, MD_REM) | op_is(md_op, MD_REMU);
  assign in_rem   = op_is(md_op, MD_REM) | op_is(md_op, MD_REMU);
  assign in_sdiv  = op_is(md_op, MD_DIV) | op_is(md_op, MD_REM);
  assign a_signed = op_is(md_op, MD_MUL) | op_is(md_op, MD_MULH) |
                    op_is(md_op, MD_MULHSU) | in_sdiv;
  assign b_signed = op_is(md_op, MD_MUL) | op_is(md_op, MD_MULH) | in_sdiv;
  assign sign_a   = a_signed & op_a[XLEN-1];
  assign sign_b   = b_signed & op_b[XLEN-1];
  assign mag_a    = sign_a ? -op_a : op_a;
  assign mag_b    = sign_b ? -op_b : op_b;

  assign div_by_zero = in_div && (op_b == '0);
  assign div_ovf     = in_sdiv && (op_a == MIN_VAL) && (op_b == '1);

  assign q_div    = op_is(op_q, MD_DIV) | op_is(op_q, MD_DIVU) |
                    op_is(op_q, MD_REM) | op_is(op_q, MD_REMU);
  assign q_rem    = op_is(op_q, MD_REM) | op_is(op_q, MD_REMU);
  assign q_mul_lo = op_is(op_q, MD_MUL);

  // Both paths work on magnitudes in {hi,lo}: shift-add product, or remainder/quotient.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_q};

`ifdef MD_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = a_signed ? {{XLEN{op_a[XLEN-1]}}, op_a} : {{XLEN{1'b0}}, op_a};
  assign fast_b    = b_signed ? {{XLEN{op_b[XLEN-1]}}, op_b} : {{XLEN{1'b0}}, op_b};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    md_result_d = md_result_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    b_d         = b_q;
    op_d        = op_q;
    neg_d       = neg_q;
    md_stall    = 1'b0;
    quo_rem     = '0;
    prod        = '0;

    case (state_q)
      IDLE: begin
        if (md_valid && !flush) begin
          md_stall = 1'b1;
          op_d     = md_op;
          hi_d     = '0;
          lo_d     = mag_a;
          b_d      = mag_b;
          neg_d    = in_rem ? sign_a : (sign_a ^ sign_b);
          if (div_by_zero) begin
            md_result_d = in_rem ? op_a : '1;
            state_d     = DONE;
          end else if (div_ovf) begin
            md_result_d = in_rem ? '0 : MIN_VAL;
            state_d     = DONE;
`ifdef MD_FAST_MUL_EN
          end else if (!in_div) begin
            md_result_d = op_is(md_op, MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
            state_d     = DONE;
`endif
          end else begin
            count_d = CNT_W'(XLEN);
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        md_stall = 1'b1;
        count_d  = count_q - CNT_W'(1);
        if (q_div) begin
          hi_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        // Last iteration: fix-up reads this cycle's hi_d/lo_d so no extra cycle is spent.
        if (count_q == CNT_W'(1)) begin
          state_d = DONE;
          if (q_div) begin
            quo_rem     = q_rem ? hi_d : lo_d;
            md_result_d = neg_q ? -quo_rem : quo_rem;
          end else begin
            prod        = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
            md_result_d = q_mul_lo ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d = IDLE;
    end
    if (flush || !rst_n) begin
      md_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      md_result_q <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      md_result_q <= md_result_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      b_q         <= b_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
    end
  end

  assign md_done   = (state_q == DONE);
  assign md_result = md_result_q;

endmodule

// File: rtl/ex_stage_md.sv
// ex_stage_md: EX stage with MEM/WB forwarding, ALU operand muxing and RV-M unit.
// MD_FAST_MUL_EN (in md_unit): single-cycle multiplies.
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ALUCODE_W = 4,
  parameter int unsigned MDOP_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ex_stage_md_if.slave         bus,
  input  logic [ALUCODE_W-1:0] ALUCode_ex,
  input  logic                 ALUSrcA_ex,
  input  logic [1:0]           ALUSrcB_ex,
  input  logic [XLEN-1:0]      Imm_ex,
  input  logic [XLEN-1:0]      PC_ex,
  input  logic [XLEN-1:0]      rs1Data_ex,
  input  logic [XLEN-1:0]      rs2Data_ex,
  input  logic [4:0]           rs1Addr_ex,
  input  logic [4:0]           rs2Addr_ex,
  output logic [XLEN-1:0]      ALUResult_ex,
  output logic [XLEN-1:0]      MemWriteData_ex,
  output logic [XLEN-1:0]      ALU_A,
  output logic [XLEN-1:0]      ALU_B
);

  fwd_sel_t        fwd_a_sel, fwd_b_sel;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd, alu_result, md_result;
  logic            md_stall, md_done;

  always_comb begin
    fwd_a_sel = fwd_select(bus.RegWrite_mem, bus.rdAddr_mem, bus.RegWrite_wb, bus.rdAddr_wb, rs1Addr_ex);
    fwd_b_sel = fwd_select(bus.RegWrite_mem, bus.rdAddr_mem, bus.RegWrite_wb, bus.rdAddr_wb, rs2Addr_ex);
    rs1_fwd   = rs1Data_ex;
    rs2_fwd   = rs2Data_ex;
    case (fwd_a_sel)
      FWD_MEM: rs1_fwd = bus.ALUResult_mem;
      FWD_WB:  rs1_fwd = bus.RegWriteData_wb;
      default: rs1_fwd = rs1Data_ex;
    endcase
    case (fwd_b_sel)
      FWD_MEM: rs2_fwd = bus.ALUResult_mem;
      FWD_WB:  rs2_fwd = bus.RegWriteData_wb;
      default: rs2_fwd = rs2Data_ex;
    endcase
  end

  always_comb begin
    ALU_A = ALUSrcA_ex ? PC_ex : rs1_fwd;
    ALU_B = rs2_fwd;
    if (ALUSrcB_ex[1]) begin
      ALU_B = XLEN'(4);
    end else if (ALUSrcB_ex[0]) begin
      ALU_B = Imm_ex;
    end
  end

  alu #(
    .XLEN      (XLEN),
    .ALUCODE_W (ALUCODE_W)
  ) u_alu (
    .ALUCode (ALUCode_ex),
    .A       (ALU_A),
    .B       (ALU_B),
    .Result  (alu_result)
  );

  md_unit #(
    .XLEN   (XLEN),
    .MDOP_W (MDOP_W)
  ) u_md_unit (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_valid  (bus.MDValid_ex),
    .md_op     (bus.MDOp_ex),
    .flush     (bus.flush_ex),
    .op_a      (rs1_fwd),
    .op_b      (rs2_fwd),
    .md_stall  (md_stall),
    .md_done   (md_done),
    .md_result (md_result)
  );

  assign bus.Stall_ex    = md_stall;
  assign MemWriteData_ex = rs2_fwd;
  assign ALUResult_ex    = md_done ? md_result : alu_result;

endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed + randomized checks of ex_stage_md against a behavioural model.
// MD_FAST_MUL_EN: selects the expected multiply stall length.
module tb_ex_stage_md;
  import ex_pkg::*;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ALUCode_ex;
  logic        ALUSrcA_ex;
  logic [1:0]  ALUSrcB_ex;
  logic [31:0] Imm_ex, PC_ex, rs1Data_ex, rs2Data_ex;
  logic [4:0]  rs1Addr_ex, rs2Addr_ex;
  logic [31:0] ALUResult_ex, MemWriteData_ex, ALU_A, ALU_B;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  ex_stage_md_if #(.XLEN(XLEN), .MDOP_W(3)) bus ();

  ex_stage_md #(.XLEN(XLEN), .ALUCODE_W(4), .MDOP_W(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .ALUCode_ex      (ALUCode_ex),
    .ALUSrcA_ex      (ALUSrcA_ex),
    .ALUSrcB_ex      (ALUSrcB_ex),
    .Imm_ex          (Imm_ex),
    .PC_ex           (PC_ex),
    .rs1Data_ex      (rs1Data_ex),
    .rs2Data_ex      (rs2Data_ex),
    .rs1Addr_ex      (rs1Addr_ex),
    .rs2Addr_ex      (rs2Addr_ex),
    .ALUResult_ex    (ALUResult_ex),
    .MemWriteData_ex (MemWriteData_ex),
    .ALU_A           (ALU_A),
    .ALU_B           (ALU_B)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    case (code)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_LUI:  return b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ua;
    longint unsigned uu;
    logic [63:0]     p;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ia = a;
    ib = b;
    case (op)
      MD_MUL:    begin p = sa * sb; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      MD_MULHU:  begin uu = longint'(ua) * longint'({32'd0, b}); p = uu; return p[63:32]; end
      MD_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      MD_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default:   return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int md_stall_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= MD_DIV) begin
      if (b == 32'd0) return 1;
      if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
    end
`ifdef MD_FAST_MUL_EN
    return 1;
`else
    return XLEN + 1;
`endif
  endfunction

  task automatic quiet_inputs();
    ALUCode_ex = ALU_ADD; ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'b00;
    Imm_ex = '0; PC_ex = '0; rs1Data_ex = '0; rs2Data_ex = '0;
    rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2;
    bus.MDValid_ex = 1'b0; bus.MDOp_ex = '0; bus.flush_ex = 1'b0;
    bus.rdAddr_mem = '0; bus.rdAddr_wb = '0; bus.ALUResult_mem = '0; bus.RegWriteData_wb = '0;
    bus.RegWrite_mem = 1'b0; bus.RegWrite_wb = 1'b0;
  endtask

  // Operands are scrambled after acceptance to prove the unit captured them.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int          cyc;
    int          exp_cyc;
    logic [31:0] exp_res;
    exp_res = md_ref(op, a, b);
    exp_cyc = md_stall_ref(op, a, b);
    bus.MDValid_ex = 1'b1; bus.MDOp_ex = op;
    rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2; rs1Data_ex = a; rs2Data_ex = b;
    #1;
    cyc = 0;
    while (bus.Stall_ex === 1'b1 && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
      rs1Data_ex = $urandom; rs2Data_ex = $urandom;
      #1;
    end
    chk({tag, "_stall"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_res"}, 64'(ALUResult_ex), 64'(exp_res));
    @(posedge clk); #1;
    bus.MDValid_ex = 1'b0;
    rs1Data_ex = '0; rs2Data_ex = '0;
  endtask

  initial begin
    logic [3:0]  code;
    logic [2:0]  op;
    logic [31:0] a, b;

    rst_n = 1'b0;
    quiet_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", 64'(bus.Stall_ex), 64'(0));
    chk("reset_result", 64'(ALUResult_ex), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_stall", 64'(bus.Stall_ex), 64'(0));

    // Forwarding priority
    rs1Addr_ex = 5'd5; rs1Data_ex = 32'h33;
    bus.RegWrite_mem = 1'b1; bus.rdAddr_mem = 5'd5; bus.ALUResult_mem = 32'h11;
    bus.RegWrite_wb = 1'b1; bus.rdAddr_wb = 5'd5; bus.RegWriteData_wb = 32'h22;
    #1; chk("fwd_mem_prio", 64'(ALU_A), 64'(32'h11));
    bus.RegWrite_mem = 1'b0;
    #1; chk("fwd_wb", 64'(ALU_A), 64'(32'h22));
    bus.RegWrite_wb = 1'b0;
    #1; chk("fwd_rf", 64'(ALU_A), 64'(32'h33));
    rs1Addr_ex = 5'd0; rs1Data_ex = 32'h5A;
    bus.RegWrite_mem = 1'b1; bus.rdAddr_mem = 5'd0; bus.ALUResult_mem = 32'hDEAD;
    #1; chk("fwd_x0", 64'(ALU_A), 64'(32'h5A));
    rs2Addr_ex = 5'd7; rs2Data_ex = 32'h77;
    bus.RegWrite_wb = 1'b1; bus.rdAddr_wb = 5'd7; bus.RegWriteData_wb = 32'h1234_5678;
    #1; chk("fwd_rs2_store", 64'(MemWriteData_ex), 64'(32'h1234_5678));
    chk("fwd_rs2_aluB", 64'(ALU_B), 64'(32'h1234_5678));
    chk("fwd_sum", 64'(ALUResult_ex), 64'(32'h1234_5678 + 32'h5A));
    quiet_inputs();

    // Operand muxes
    PC_ex = 32'h0000_1000; Imm_ex = 32'hFFFF_FFF0; rs1Data_ex = 32'h9; rs2Data_ex = 32'h3;
    ALUSrcA_ex = 1'b1; ALUSrcB_ex = 2'b01;
    #1; chk("mux_pc", 64'(ALU_A), 64'(32'h1000)); chk("mux_imm", 64'(ALU_B), 64'(32'hFFFF_FFF0));
    ALUSrcB_ex = 2'b10;
    #1; chk("mux_four", 64'(ALU_B), 64'(4)); chk("mux_pc4", 64'(ALUResult_ex), 64'(32'h1004));
    ALUSrcB_ex = 2'b11;
    #1; chk("mux_four_b11", 64'(ALU_B), 64'(4));
    quiet_inputs();

    // Random ALU operations, no M-op in flight
    for (int i = 0; i < 20; i++) begin
      code = 4'($urandom_range(0, 10));
      a = $urandom; b = $urandom;
      ALUCode_ex = code; rs1Data_ex = a; rs2Data_ex = b;
      #1;
      chk("alu_rand", 64'(ALUResult_ex), 64'(alu_ref(code, a, b)));
      chk("alu_rand_stall", 64'(bus.Stall_ex), 64'(0));
    end
    quiet_inputs();
    @(posedge clk); #1;

    // Flush in IDLE suppresses acceptance
    bus.MDValid_ex = 1'b1; bus.MDOp_ex = MD_DIV; bus.flush_ex = 1'b1;
    rs1Data_ex = 32'd9; rs2Data_ex = 32'd3;
    #1; chk("flush_idle_stall", 64'(bus.Stall_ex), 64'(0));
    @(posedge clk); #1;
    bus.MDValid_ex = 1'b0; bus.flush_ex = 1'b0;
    #1; chk("flush_idle_after", 64'(bus.Stall_ex), 64'(0));

    // Directed M-ops
    run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_md(MD_REM, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_md(MD_DIVU, 32'hCAFE_0001, 32'd0, "divu_by0");
    run_md(MD_REM, 32'h0000_1234, 32'd0, "rem_by0");
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_md(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_md(MD_MULH, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    run_md(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    run_md(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    run_md(MD_DIV, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    run_md(MD_REMU, 32'd100, 32'd7, "remu_100_7");

    // Random M-ops
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_md(op, a, b, "md_rand");
    end

    // Flush during BUSY
    bus.MDValid_ex = 1'b1; bus.MDOp_ex = MD_DIVU; rs1Data_ex = 32'd5; rs2Data_ex = 32'd7;
    #1; chk("busy_flush_accept", 64'(bus.Stall_ex), 64'(1));
    repeat (10) begin @(posedge clk); #1; end
    chk("busy10_stall", 64'(bus.Stall_ex), 64'(1));
    bus.flush_ex = 1'b1; bus.MDValid_ex = 1'b0;
    #1; chk("busy_flush_stall", 64'(bus.Stall_ex), 64'(0));
    @(posedge clk); #1;
    bus.flush_ex = 1'b0;
    #1; chk("post_flush_stall", 64'(bus.Stall_ex), 64'(0));
    chk("post_flush_alu", 64'(ALUResult_ex), 64'(32'd12));
    repeat (40) @(posedge clk);
    #1; chk("post_flush_quiet", 64'(bus.Stall_ex), 64'(0));

    // Reset during BUSY
    bus.MDValid_ex = 1'b1; bus.MDOp_ex = MD_DIVU; rs1Data_ex = 32'd100; rs2Data_ex = 32'd3;
    #1;
    repeat (10) begin @(posedge clk); #1; end
    chk("busy10_stall_rst", 64'(bus.Stall_ex), 64'(1));
    rst_n = 1'b0; bus.MDValid_ex = 1'b0;
    #1; chk("busy_reset_stall", 64'(bus.Stall_ex), 64'(0));
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_busy_stall", 64'(bus.Stall_ex), 64'(0));
    chk("post_reset_alu", 64'(ALUResult_ex), 64'(32'd103));
    run_md(MD_MUL, 32'd3, 32'd4, "mul_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parametrised next-generation execute stage for the RV32/RV64 pipeline.
- Keeps the MEM/WB operand forwarding and ALU operand muxing of the current EX stage.
- Adds a multi-cycle RV-M multiply/divide path with an FSM and a pipeline stall handshake.
- Sits between the ID/EX and EX/MEM pipeline registers; Stall_ex freezes PC, IF/ID and ID/EX.

Parameters:
XLEN, 32, datapath width (32 or 64)
ALUCODE_W, 4, width of ALUCode_ex
MDOP_W, 3, width of MDOp_ex

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ALUCode_ex  input  ALUCODE_W  ALU operation
- MDValid_ex  input  1  the instruction in EX is an M-extension op
- MDOp_ex  input  MDOP_W  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- ALUSrcA_ex  input  1  ALU A source: 0 = forwarded rs1, 1 = PC_ex
- ALUSrcB_ex  input  2  ALU B source: 00 = forwarded rs2, 01 = Imm_ex, 1x = constant 4
- Imm_ex, PC_ex, rs1Data_ex, rs2Data_ex  input  XLEN  operands
- rs1Addr_ex, rs2Addr_ex, rdAddr_mem, rdAddr_wb  input  5  register addresses
- ALUResult_mem, RegWriteData_wb  input  XLEN  forwarding sources
- RegWrite_mem, RegWrite_wb  input  1  write enables of the forwarding sources
- flush_ex  input  1  kill the instruction currently in EX
- ALUResult_ex  output  XLEN  ALU result, or M-op result in DONE
- MemWriteData_ex  output  XLEN  forwarded rs2
- ALU_A, ALU_B  output  XLEN  muxed ALU operands
- Stall_ex  output  1  hold upstream stages

Behaviour:
- Forwarding, per source operand; priority is MEM, then WB, then register file:
  - select MEM if RegWrite_mem && rdAddr_mem!=0 && rdAddr_mem==rsX;
  - else select WB if RegWrite_wb && rdAddr_wb!=0 && rdAddr_wb==rsX;
  - else use rsXData_ex.
- The ALU path is combinational, zero latency; the existing ALU module is instantiated unchanged.
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Register reset values: count=0, md_result=0, operand registers=0; Stall_ex=0 out of reset.
- IDLE:
  - If MDValid_ex && !flush_ex: latch the forwarded operands (they must be captured here because MEM/WB keep advancing during the stall) and assert Stall_ex.
  - Special cases (div/rem by zero; signed overflow MIN/-1) load md_result directly and go to DONE.
  - Otherwise load count=XLEN and go to BUSY.
- BUSY:
  - Stall_ex=1; one radix-2 iteration per cycle (shift-add multiply, restoring divide on magnitudes); count decrements each cycle.
  - At count==1, apply sign fix-up, load md_result and go to DONE.
- DONE:
  - Stall_ex=0 and ALUResult_ex=md_result; the pipeline advances at this edge and the FSM returns to IDLE.
  - A back-to-back M-op is not re-accepted in DONE; it is accepted next cycle from IDLE.
- Stall counts: a normal op stalls XLEN+1 cycles; a special case stalls 1 cycle.
- Result rules:
  - MUL returns the low XLEN bits of the product; MULH/MULHSU/MULHU return the high XLEN bits with the given signedness.
  - Divide by zero: quotient all-ones, remainder = dividend.
  - MIN/-1: quotient = MIN, remainder = 0.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- flush_ex: from any state, go to IDLE at the next edge; Stall_ex is forced 0 combinationally in the same cycle.
- rst_n asserted mid-operation: immediate IDLE, Stall_ex=0; the partial result is discarded.
- MDValid_ex=0: Stall_ex stays 0 and ALUResult_ex is the ALU output.

Optional Feature:
- Macro: MD_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 2*XLEN-bit product; IDLE goes straight to DONE, giving a 1-cycle stall. Division is unchanged.
- Undefined: multiplies use the iterative path with an XLEN+1-cycle stall.

Decomposition:
- Package ex_pkg holds:
  - the ALUCode constants;
  - the MDOp encodings;
  - the md_state_t enum (IDLE/BUSY/DONE);
  - the forwarding-select enum (FWD_RF/FWD_WB/FWD_MEM).
- Sub-module md_unit holds the FSM, counter, iterative mul/div, special cases and fix-up.
- ex_stage_md keeps the forwarding logic, muxes, ALU instance and output select.

Test Plan:
- Priority: rs1Addr=5 with MEM rd=5 writing 0x11 and WB rd=5 writing 0x22 -> ALU_A=0x11. Drop RegWrite_mem -> ALU_A=0x22.
- x0: rs1Addr=0 with rdAddr_mem=0, RegWrite_mem=1, ALUResult_mem=0xDEAD -> ALU_A=rs1Data_ex.
- DIV -7/2 (XLEN=32) -> Stall_ex high 33 cycles, then ALUResult_ex=0xFFFFFFFD; REM -> 0xFFFFFFFF.
- DIVU x/0 -> 0xFFFFFFFF after a 1-cycle stall; REM 0x1234/0 -> 0x1234; DIV 0x80000000/-1 -> 0x80000000.
- MULH 0x80000000*0x80000000 -> 0x40000000. Stall is 33 cycles, or 1 cycle with MD_FAST_MUL_EN.
- Assert flush_ex, then rst_n low, at BUSY cycle 10 -> Stall_ex=0 the same cycle; FSM IDLE; the next MUL 3*4 -> 12.
